instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage feeding Instruction_Memory: owns the program counter, drives the
//   word address into the memory, and captures the returned instruction in the
//   IF/ID pipeline register for decode. Handles stall, flush/redirect and
//   fetch-fault detection. Sits between branch/jump resolution and decode.
// PARAMETERS
//   RESET_PC    32'h0000_0000  byte address loaded into PC on reset
//   IMEM_DEPTH  256            instruction memory size in 32-bit words
//   NOP_INST    32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
//   clk          in   1   system clock; all state updates on rising edge
//   rst          in   1   synchronous, active-high reset
//   stall        in   1   hold PC and IF/ID register this cycle
//   flush        in   1   redirect fetch to redirect_pc; squash IF/ID
//   redirect_pc  in   32  branch/jump target, byte address
//   imem_addr    out  32  word index to instruction memory (pc >> 2)
//   imem_inst    in   32  instruction from memory, combinational same cycle
//   pc           out  32  current fetch PC, byte address
//   if_id_pc     out  32  PC of instruction held in IF/ID
//   if_id_inst   out  32  instruction held in IF/ID
//   if_id_valid  out  1   IF/ID holds a real instruction
//   fault        out  1   sticky fetch fault (misaligned/out-of-range PC)
// BEHAVIOUR
//   Reset (rst=1 at edge): pc=RESET_PC, if_id_pc=0, if_id_inst=NOP_INST,
//     if_id_valid=0, fault=0, state=RUN. rst overrides every other input.
//   imem_addr = {2'b00, pc[31:2]}, combinational; memory read is zero-latency,
//     so imem_inst for pc is captured at the same edge that advances pc.
//   FSM states: RUN, HALT.
//   RUN, priority flush > stall > normal:
//     flush=1: pc<=redirect_pc; if_id_inst<=NOP_INST; if_id_valid<=0;
//       if_id_pc<=0. Flush wins over simultaneous stall.
//     stall=1 (flush=0): pc and all IF/ID outputs hold.
//     normal: if_id_pc<=pc; if_id_inst<=imem_inst; if_id_valid<=1; pc<=pc+4.
//   Fault check, RUN only, evaluated on the value about to be loaded into pc:
//     next_pc[1:0]!=0 or (next_pc>>2)>=IMEM_DEPTH -> fault<=1, state<=HALT;
//     pc keeps its old value; IF/ID updates normally that edge.
//   HALT: pc frozen; if_id_inst<=NOP_INST, if_id_valid<=0 each cycle; flush and
//     stall ignored; fault stays 1. Leaves HALT only via rst.
//   Width: pc+4 is 32-bit modulo; the wrap at 32'hFFFF_FFFC is out of range
//     and caught by the fault check before any wrap reaches pc.
//   Latency: instruction at pc appears on if_id_* 1 cycle after pc is
//     presented; redirect target is fetched 1 cycle after flush.
//   Reset mid-stall/flush: state fully reinitialised; no IF/ID content survives.
// TESTING
//   1 Reset, stall=flush=0, mem[0..3]=A,B,C,D -> if_id_inst A,B,C,D on cycles
//     1..4; if_id_pc 0,4,8,12; if_id_valid=1 from cycle 1.
//   2 Stall 2 cycles after fetching B -> pc=8 and if_id_inst=B held 2 cycles,
//     then C at pc=8.
//   3 flush=1, stall=1, redirect_pc=0x40 -> next cycle pc=0x40, if_id_valid=0,
//     if_id_inst=0x13; following cycle if_id_pc=0x40, if_id_inst=mem[16].
//   4 flush with redirect_pc=0x42 -> fault=1, pc unchanged, if_id_valid=0
//     afterwards; later flush ignored; rst clears fault, pc=RESET_PC.
//   5 Run sequentially to pc=0x3FC (IMEM_DEPTH=256) -> mem[255] captured,
//     fault=1, pc stays 0x3FC, HALT entered.
//   6 Assert rst mid-stall with if_id_valid=1 -> next cycle all outputs at
//     reset values, fetch resumes from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: decode-side control, instruction memory port and IF/ID outputs.
// master = fetch unit, slave = surrounding pipeline/memory.
interface instr_fetch_unit_if;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        fault;

    modport master (
        input  stall, flush, redirect_pc, imem_inst,
        output imem_addr, pc, if_id_pc, if_id_inst, if_id_valid, fault
    );

    modport slave (
        output stall, flush, redirect_pc, imem_inst,
        input  imem_addr, pc, if_id_pc, if_id_inst, if_id_valid, fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses a zero-latency instruction memory and
// fills the IF/ID register; halts with a sticky fault on a bad next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_unit_if.master    bus
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        fault_q, fault_d;
    logic        load_pc;
    logic [31:0] next_pc;

    assign bus.imem_addr   = {2'b00, pc_q[31:2]};
    assign bus.pc          = pc_q;
    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_inst  = if_id_inst_q;
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.fault       = fault_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        fault_d       = fault_q;
        load_pc       = 1'b0;
        next_pc       = pc_q;

        case (state_q)
            RUN: begin
                if (bus.flush) begin
                    load_pc       = 1'b1;
                    next_pc       = bus.redirect_pc;
                    if_id_pc_d    = '0;
                    if_id_inst_d  = NOP_INST;
                    if_id_valid_d = 1'b0;
                end else if (!bus.stall) begin
                    load_pc       = 1'b1;
                    next_pc       = pc_q + 32'd4;
                    if_id_pc_d    = pc_q;
                    if_id_inst_d  = bus.imem_inst;
                    if_id_valid_d = 1'b1;
                end

                // A bad target never reaches pc; IF/ID still takes this edge's update.
                if (load_pc) begin
                    if (next_pc[1:0] != 2'b00 || {2'b00, next_pc[31:2]} >= IMEM_DEPTH) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            HALT: begin
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            fault_q       <= fault_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// stall/flush/reset traffic checked against a cycle-level behavioural model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    logic [31:0] mem [256];

    // Reference model state
    logic [31:0] m_pc, m_ipc, m_inst;
    logic        m_valid, m_fault, m_halt;

    instr_fetch_unit_if ifc ();

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(256),
        .NOP_INST  (NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    always_comb ifc.imem_inst = mem[ifc.imem_addr[7:0]];

    function automatic logic [161:0] act_vec();
        return {ifc.pc, ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid, ifc.fault, ifc.imem_addr};
    endfunction

    function automatic logic [161:0] exp_vec();
        return {m_pc, m_ipc, m_inst, m_valid, m_fault, m_pc / 32'd4};
    endfunction

    // Apply one cycle of inputs, advance the model by the same edge, sample at negedge.
    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] rd);
        logic [31:0] tgt;
        rst = r;
        ifc.stall = s;
        ifc.flush = f;
        ifc.redirect_pc = rd;
        if (r) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_inst = NOP;
            m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_inst = NOP; m_valid = 1'b0;
        end else begin
            tgt = f ? rd : m_pc + 32'd4;
            if (f) begin
                m_ipc = 32'h0; m_inst = NOP; m_valid = 1'b0;
            end else if (!s) begin
                m_ipc = m_pc; m_inst = mem[m_pc[9:2]]; m_valid = 1'b1;
            end
            if (f || !s) begin
                if (tgt % 4 != 0 || tgt / 4 >= 256) begin
                    m_fault = 1'b1; m_halt = 1'b1;
                end else begin
                    m_pc = tgt;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.pc, ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid, ifc.fault} !==
            {32'h0, 32'h0, NOP, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_values act=%h exp=%h",
                     {ifc.pc, ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid, ifc.fault},
                     {32'h0, 32'h0, NOP, 1'b0, 1'b0});
        end
    endtask

    task automatic test_sequential();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            vecs++;
            if ({ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid} !== {32'(i * 4), mem[i], 1'b1}) begin
                errs++;
                $display("FAIL seq_ifid[%0d] act=%h exp=%h", i,
                         {ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid}, {32'(i * 4), mem[i], 1'b1});
            end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            vecs++;
            if ({ifc.pc, ifc.if_id_inst, ifc.if_id_valid} !== {32'h8, mem[1], 1'b1}) begin
                errs++;
                $display("FAIL stall_hold[%0d] act=%h exp=%h", i,
                         {ifc.pc, ifc.if_id_inst, ifc.if_id_valid}, {32'h8, mem[1], 1'b1});
            end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.if_id_pc, ifc.if_id_inst, ifc.pc} !== {32'h8, mem[2], 32'hC}) begin
            errs++;
            $display("FAIL stall_resume act=%h exp=%h",
                     {ifc.if_id_pc, ifc.if_id_inst, ifc.pc}, {32'h8, mem[2], 32'hC});
        end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b1, 1'b1, 32'h40);
        vecs++;
        if ({ifc.pc, ifc.if_id_valid, ifc.if_id_inst, ifc.imem_addr} !== {32'h40, 1'b0, NOP, 32'h10}) begin
            errs++;
            $display("FAIL flush_redirect act=%h exp=%h",
                     {ifc.pc, ifc.if_id_valid, ifc.if_id_inst, ifc.imem_addr}, {32'h40, 1'b0, NOP, 32'h10});
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid} !== {32'h40, mem[16], 1'b1}) begin
            errs++;
            $display("FAIL flush_target_fetch act=%h exp=%h",
                     {ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid}, {32'h40, mem[16], 1'b1});
        end
    endtask

    task automatic test_fault_redirect();
        logic [31:0] pc_before;
        pc_before = ifc.pc;
        step(1'b0, 1'b0, 1'b1, 32'h42);
        vecs++;
        if ({ifc.fault, ifc.pc, ifc.if_id_valid} !== {1'b1, pc_before, 1'b0}) begin
            errs++;
            $display("FAIL misaligned_fault act=%h exp=%h",
                     {ifc.fault, ifc.pc, ifc.if_id_valid}, {1'b1, pc_before, 1'b0});
        end
        step(1'b0, 1'b0, 1'b1, 32'h80);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.fault, ifc.pc, ifc.if_id_valid, ifc.if_id_inst} !== {1'b1, pc_before, 1'b0, NOP}) begin
            errs++;
            $display("FAIL halt_ignores_flush act=%h exp=%h",
                     {ifc.fault, ifc.pc, ifc.if_id_valid, ifc.if_id_inst}, {1'b1, pc_before, 1'b0, NOP});
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.fault, ifc.pc} !== {1'b0, 32'h0}) begin
            errs++;
            $display("FAIL reset_clears_fault act=%h exp=%h", {ifc.fault, ifc.pc}, {1'b0, 32'h0});
        end
    endtask

    task automatic test_end_of_memory();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 255; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.pc, ifc.fault} !== {32'h3FC, 1'b0}) begin
            errs++;
            $display("FAIL eom_reach act=%h exp=%h", {ifc.pc, ifc.fault}, {32'h3FC, 1'b0});
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.pc, ifc.fault, ifc.if_id_inst, ifc.if_id_pc, ifc.if_id_valid} !==
            {32'h3FC, 1'b1, mem[255], 32'h3FC, 1'b1}) begin
            errs++;
            $display("FAIL eom_fault act=%h exp=%h",
                     {ifc.pc, ifc.fault, ifc.if_id_inst, ifc.if_id_pc, ifc.if_id_valid},
                     {32'h3FC, 1'b1, mem[255], 32'h3FC, 1'b1});
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.pc, ifc.if_id_valid, ifc.if_id_inst} !== {32'h3FC, 1'b0, NOP}) begin
            errs++;
            $display("FAIL eom_halted act=%h exp=%h",
                     {ifc.pc, ifc.if_id_valid, ifc.if_id_inst}, {32'h3FC, 1'b0, NOP});
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h80);
        vecs++;
        if ({ifc.pc, ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid, ifc.fault} !==
            {32'h0, 32'h0, NOP, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid_stall act=%h exp=%h",
                     {ifc.pc, ifc.if_id_pc, ifc.if_id_inst, ifc.if_id_valid, ifc.fault},
                     {32'h0, 32'h0, NOP, 1'b0, 1'b0});
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vecs++;
        if ({ifc.if_id_pc, ifc.if_id_inst, ifc.pc} !== {32'h0, mem[0], 32'h4}) begin
            errs++;
            $display("FAIL resume_after_reset act=%h exp=%h",
                     {ifc.if_id_pc, ifc.if_id_inst, ifc.pc}, {32'h0, mem[0], 32'h4});
        end
    endtask

    task automatic test_random();
        logic        r, s, f;
        logic [31:0] rd;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 15) == 0) ? $urandom() : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            step(r, s, f, rd);
            vecs++;
            if (act_vec() !== exp_vec()) begin
                errs++;
                $display("FAIL random[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.stall = 1'b0;
        ifc.flush = 1'b0;
        ifc.redirect_pc = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom();

        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_fault_redirect();
        test_end_of_memory();
        test_reset_mid_stall();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
